// File: rtl/bp_types_pkg.sv
// Shared types, constants and index helper for the branch predictor table.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package bp_types_pkg;

    // Default counter width. Parameterised instances derive their own limits
    // through the helper functions below.
    localparam int CTR_WIDTH_DEFAULT = 2;

    typedef logic [CTR_WIDTH_DEFAULT-1:0] ctr_t;

    localparam ctr_t CTR_MAX = '1;
    localparam ctr_t CTR_WNT = ctr_t'((1 << (CTR_WIDTH_DEFAULT - 1)) - 1);

    // Weakly-not-taken value for a counter of width w: MSB clear, all lower bits set.
    function automatic int ctr_wnt(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Word index of the PC, folded with the (zero-extended) global history.
    // Callers keep only the low log2(ENTRIES) bits of the result.
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] ghr);
        return {2'b00, pc[31:2]} ^ ghr;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One saturating up/down prediction counter; resets to weakly-not-taken.
// Latency: new value visible the cycle after en is sampled.
// Backpressure: none; accepts a step every cycle.
module bp_sat_counter
    import bp_types_pkg::*;
#(
    parameter int CTR_WIDTH = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 en,
    input  logic                 inc,
    output logic [CTR_WIDTH-1:0] value
);

    localparam logic [CTR_WIDTH-1:0] MAX = '1;
    localparam logic [CTR_WIDTH-1:0] WNT = CTR_WIDTH'(ctr_wnt(CTR_WIDTH));

    logic [CTR_WIDTH-1:0] value_q;
    logic [CTR_WIDTH-1:0] value_d;

    // Step up or down, holding at either end rather than wrapping.
    always_comb begin
        value_d = value_q;
        if (en) begin
            if (inc) begin
                if (value_q != MAX) value_d = value_q + CTR_WIDTH'(1);
            end else begin
                if (value_q != '0) value_d = value_q - CTR_WIDTH'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) value_q <= WNT;
        else     value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/branch_predictor_table.sv
// Table of saturating branch counters with same-cycle lookup and a mispredict statistic.
// Latency: lookup combinational (zero cycles); updates visible the next cycle, no bypass.
// Backpressure: none; one update accepted every cycle. BP_GSHARE_EN adds a global history XOR.
module branch_predictor_table
    import bp_types_pkg::*;
#(
    parameter int ENTRIES    = 16,
    parameter int CTR_WIDTH  = 2,
    parameter int STAT_WIDTH = 16,
    parameter int GHR_WIDTH  = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [31:0]                 lookup_pc,
    output logic                        predict_taken,
    output logic [$clog2(ENTRIES)-1:0]  predict_idx,
    input  logic                        update_en,
    input  logic [$clog2(ENTRIES)-1:0]  update_idx,
    input  logic                        update_taken,
    input  logic                        update_mispredict,
    input  logic                        stat_clear,
    output logic [STAT_WIDTH-1:0]       mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Build-time sanity: index slicing only covers the table for power-of-two sizes.
    if (ENTRIES < 2 || ENTRIES > 256 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_predictor_table: ENTRIES must be a power of two in 2..256");
    end
    if (CTR_WIDTH < 1 || CTR_WIDTH > 4) begin : g_bad_ctr
        $error("branch_predictor_table: CTR_WIDTH must be 1..4");
    end

    logic [CTR_WIDTH-1:0] ctr_val [ENTRIES];
    logic [31:0]          ghr_ext;

    // One counter per entry; only the addressed entry steps on an update.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        bp_sat_counter #(
            .CTR_WIDTH (CTR_WIDTH)
        ) u_ctr (
            .CLK   (CLK),
            .RST   (RST),
            .en    (update_en && (update_idx == IDX_W'(i))),
            .inc   (update_taken),
            .value (ctr_val[i])
        );
    end

`ifdef BP_GSHARE_EN
    if (GHR_WIDTH < 1 || GHR_WIDTH > IDX_W) begin : g_bad_ghr
        $error("branch_predictor_table: GHR_WIDTH must be 1..log2(ENTRIES)");
    end

    logic [GHR_WIDTH-1:0] ghr_q;
    logic [GHR_WIDTH-1:0] ghr_d;

    // Shift every resolved outcome in at the LSB, mispredicted or not.
    always_comb begin
        ghr_d = ghr_q;
        if (update_en) ghr_d = GHR_WIDTH'({ghr_q, update_taken});
    end

    // Global history register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end

    assign ghr_ext = 32'(ghr_q);
`else
    assign ghr_ext = '0;
`endif

    // Index is sent down the pipe so the update lands on the entry that predicted,
    // even when history has moved on. Reset values have MSB clear, so the
    // prediction is not-taken throughout reset without extra gating.
    assign predict_idx   = IDX_W'(bp_index(lookup_pc, ghr_ext));
    assign predict_taken = ctr_val[predict_idx][CTR_WIDTH-1];

    logic [STAT_WIDTH-1:0] stat_q;
    logic [STAT_WIDTH-1:0] stat_d;

    // Mispredict statistic: clear wins over increment; holds at all-ones.
    always_comb begin
        stat_d = stat_q;
        if (stat_clear) begin
            stat_d = '0;
        end else if (update_en && update_mispredict && (stat_q != '1)) begin
            stat_d = stat_q + STAT_WIDTH'(1);
        end
    end

    // Statistic register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) stat_q <= '0;
        else     stat_q <= stat_d;
    end

    assign mispredict_count = stat_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
module tb_branch_predictor_table;

    logic        CLK;
    logic        RST;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic [3:0]  predict_idx;
    logic        update_en;
    logic [3:0]  update_idx;
    logic        update_taken;
    logic        update_mispredict;
    logic        stat_clear;
    logic [3:0]  mispredict_count;

    int pass_cnt;
    int total_cnt;

    branch_predictor_table #(
        .ENTRIES    (16),
        .CTR_WIDTH  (2),
        .STAT_WIDTH (4),
        .GHR_WIDTH  (4)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .lookup_pc         (lookup_pc),
        .predict_taken     (predict_taken),
        .predict_idx       (predict_idx),
        .update_en         (update_en),
        .update_idx        (update_idx),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .stat_clear        (stat_clear),
        .mispredict_count  (mispredict_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Apply one update for a single cycle; returns at the following negedge.
    task automatic do_update(input logic [3:0] idx, input logic taken, input logic misp);
        @(negedge CLK);
        update_en         = 1'b1;
        update_idx        = idx;
        update_taken      = taken;
        update_mispredict = misp;
        @(negedge CLK);
        update_en         = 1'b0;
        update_mispredict = 1'b0;
    endtask

    // Point lookup at an index and check the prediction.
    task automatic check_pred(input string name, input logic [3:0] idx, input logic exp);
        lookup_pc = {26'd0, idx, 2'b00};
        #1;
        total_cnt++;
        if (predict_taken !== exp) $display("FAIL %s: predict_taken=%b expected %b", name, predict_taken, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        lookup_pc = 32'h0000_0040;
        #2;
        total_cnt++;
        if (predict_idx !== 4'd0) $display("FAIL reset_idx: predict_idx=%0d expected 0", predict_idx);
        else pass_cnt++;
        total_cnt++;
        if (predict_taken !== 1'b0) $display("FAIL reset_taken: predict_taken=%b expected 0", predict_taken);
        else pass_cnt++;
        total_cnt++;
        if (mispredict_count !== 4'd0) $display("FAIL reset_count: count=%0d expected 0", mispredict_count);
        else pass_cnt++;
        lookup_pc = 32'h0000_0047;
        #1;
        total_cnt++;
        if (predict_idx !== 4'd1) $display("FAIL reset_idx_low_bits: predict_idx=%0d expected 1", predict_idx);
        else pass_cnt++;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lookup_pc = 32'h1000_0000 | (i << 2);
            #1;
            total_cnt++;
            if (predict_idx !== 4'(i)) $display("FAIL sweep_idx%0d: predict_idx=%0d expected %0d", i, predict_idx, i);
            else pass_cnt++;
            total_cnt++;
            if (predict_taken !== 1'b0) $display("FAIL sweep_taken%0d: predict_taken=%b expected 0", i, predict_taken);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturate_up();
        check_pred("up_init", 4'd5, 1'b0);
        do_update(4'd5, 1'b1, 1'b0);
        check_pred("up_1", 4'd5, 1'b1);
        do_update(4'd5, 1'b1, 1'b0);
        check_pred("up_2", 4'd5, 1'b1);
        do_update(4'd5, 1'b1, 1'b0);
        check_pred("up_3", 4'd5, 1'b1);
        do_update(4'd5, 1'b0, 1'b0);
        check_pred("up_back_10", 4'd5, 1'b1);
        do_update(4'd5, 1'b0, 1'b0);
        check_pred("up_back_01", 4'd5, 1'b0);
        check_pred("up_neighbour", 4'd4, 1'b0);
    endtask

    task automatic test_saturate_down();
        do_update(4'd3, 1'b0, 1'b0);
        check_pred("down_00", 4'd3, 1'b0);
        do_update(4'd3, 1'b0, 1'b0);
        check_pred("down_hold", 4'd3, 1'b0);
        do_update(4'd3, 1'b1, 1'b0);
        check_pred("down_then_01", 4'd3, 1'b0);
        do_update(4'd3, 1'b1, 1'b0);
        check_pred("down_then_10", 4'd3, 1'b1);
    endtask

    task automatic test_same_cycle();
        @(negedge CLK);
        lookup_pc    = 32'h0000_001C;
        update_en    = 1'b1;
        update_idx   = 4'd7;
        update_taken = 1'b1;
        #1;
        total_cnt++;
        if (predict_taken !== 1'b0) $display("FAIL same_cycle_old: predict_taken=%b expected 0", predict_taken);
        else pass_cnt++;
        @(negedge CLK);
        update_en = 1'b0;
        #1;
        total_cnt++;
        if (predict_taken !== 1'b1) $display("FAIL same_cycle_new: predict_taken=%b expected 1", predict_taken);
        else pass_cnt++;
    endtask

    task automatic test_stat();
        @(negedge CLK);
        update_mispredict = 1'b1;
        @(negedge CLK);
        update_mispredict = 1'b0;
        total_cnt++;
        if (mispredict_count !== 4'd0) $display("FAIL stat_unqualified: count=%0d expected 0", mispredict_count);
        else pass_cnt++;
        for (int i = 1; i <= 20; i++) begin
            do_update(4'd10, 1'b0, 1'b1);
            if (i == 3 || i == 15 || i == 20) begin
                total_cnt++;
                if (mispredict_count !== 4'(i > 15 ? 15 : i))
                    $display("FAIL stat_after_%0d: count=%0d expected %0d", i, mispredict_count, (i > 15 ? 15 : i));
                else pass_cnt++;
            end
        end
        @(negedge CLK);
        stat_clear = 1'b1;
        update_en = 1'b1;
        update_idx = 4'd10;
        update_taken = 1'b0;
        update_mispredict = 1'b1;
        @(negedge CLK);
        stat_clear = 1'b0;
        update_en = 1'b0;
        update_mispredict = 1'b0;
        total_cnt++;
        if (mispredict_count !== 4'd0) $display("FAIL stat_clear_priority: count=%0d expected 0", mispredict_count);
        else pass_cnt++;
        do_update(4'd10, 1'b0, 1'b1);
        total_cnt++;
        if (mispredict_count !== 4'd1) $display("FAIL stat_restart: count=%0d expected 1", mispredict_count);
        else pass_cnt++;
        check_pred("stat_keeps_ctr", 4'd7, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        update_en = 1'b1;
        update_idx = 4'd5;
        update_taken = 1'b1;
        update_mispredict = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        lookup_pc = 32'h0000_001C;
        #1;
        total_cnt++;
        if (predict_taken !== 1'b0) $display("FAIL midreset_ctr: predict_taken=%b expected 0", predict_taken);
        else pass_cnt++;
        total_cnt++;
        if (mispredict_count !== 4'd0) $display("FAIL midreset_count: count=%0d expected 0", mispredict_count);
        else pass_cnt++;
        @(negedge CLK);
        update_en = 1'b0;
        update_mispredict = 1'b0;
        RST = 1'b0;
        check_pred("midreset_idx5", 4'd5, 1'b0);
        do_update(4'd5, 1'b1, 1'b0);
        check_pred("midreset_wnt", 4'd5, 1'b1);
    endtask

`ifdef BP_GSHARE_EN
    task automatic test_gshare();
        do_update(4'd0, 1'b1, 1'b0);
        do_update(4'd0, 1'b1, 1'b0);
        do_update(4'd0, 1'b0, 1'b1);
        do_update(4'd0, 1'b1, 1'b0);
        lookup_pc = 32'h0000_0008;
        #1;
        total_cnt++;
        if (predict_idx !== 4'd15) $display("FAIL gshare_idx: predict_idx=%0d expected 15", predict_idx);
        else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        RST = 1'b1;
        lookup_pc = '0;
        update_en = 1'b0;
        update_idx = '0;
        update_taken = 1'b0;
        update_mispredict = 1'b0;
        stat_clear = 1'b0;
        test_reset();
`ifdef BP_GSHARE_EN
        test_gshare();
`else
        test_saturate_up();
        test_saturate_down();
        test_same_cycle();
        test_stat();
        test_reset_mid();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
